// File: rtl/pe_mcast_scatter.sv
// Multicast scatter front-end for a PE grid. Weight beats are sent onto the
// row-tagged Y bus and image beats onto the column-tagged X bus. Each channel
// is buffered by its own 4-deep FIFO, and beats whose tag is out of range are dropped.

// Small 4-entry FIFO. The caller only pops when the FIFO is not empty and
// only pushes when it is not full.
module pe_mcast_fifo #(
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);
  logic [DW-1:0] mem_q [4];
  logic [1:0]    wp_q, rp_q;
  logic [2:0]    cnt_q;

  assign dout  = mem_q[rp_q];
  assign empty = (cnt_q == 3'd0);
  assign full  = (cnt_q == 3'd4);

  // Storage array; it has no reset because occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 2'd1;
      if (pop)  rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_q + {2'b0, push} - {2'b0, pop};
    end
  end
endmodule

module pe_mcast_scatter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  w_count,
  input  logic [7:0]  i_count,
  input  logic [15:0] w_data,
  input  logic [3:0]  w_tag,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [15:0] i_data,
  input  logic [3:0]  i_tag,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic        grid_stall,
  output logic [15:0] weight_val_in,
  output logic [3:0]  tag_row,
  output logic        valid_y,
  output logic [15:0] image_val_in,
  output logic [3:0]  tag_col,
  output logic        valid_x,
  output logic        busy,
  output logic        done,
  output logic [7:0]  drop_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e      state_q;
  logic [7:0]  wcnt_q, icnt_q, wacc_q, iacc_q, drop_q, drop_d;
  logic [19:0] w_dout, i_dout;
  logic        w_empty, w_full, i_empty, i_full;
  logic        w_fire, i_fire, w_drop, i_drop, w_pop, i_pop, emit;
  logic [15:0] wval_q, ival_q;
  logic [3:0]  row_q, col_q;
  logic        vy_q, vx_q;
  logic [8:0]  drop_sum;

  // Ready ignores a pop in the same cycle, so a full FIFO always stalls upstream.
  assign w_ready = (state_q == RUN) && !w_full && (wacc_q < wcnt_q);
  assign i_ready = (state_q == RUN) && !i_full && (iacc_q < icnt_q);
  assign w_fire  = w_valid && w_ready;
  assign i_fire  = i_valid && i_ready;
  assign w_drop  = w_fire && (w_tag > 4'd11);
  assign i_drop  = i_fire && (i_tag > 4'd13);

  assign emit  = ((state_q == RUN) || (state_q == FLUSH)) && !grid_stall;
  assign w_pop = emit && !w_empty;
  assign i_pop = emit && !i_empty;

  pe_mcast_fifo #(.DW(20)) u_wfifo (
    .clk(clk), .rst(rst), .push(w_fire && !w_drop), .din({w_tag, w_data}),
    .pop(w_pop), .dout(w_dout), .empty(w_empty), .full(w_full));

  pe_mcast_fifo #(.DW(20)) u_ififo (
    .clk(clk), .rst(rst), .push(i_fire && !i_drop), .din({i_tag, i_data}),
    .pop(i_pop), .dout(i_dout), .empty(i_empty), .full(i_full));

  // The drop counter saturates at 255. Both channels can drop a beat in the same cycle.
  always_comb begin
    drop_sum = {1'b0, drop_q} + {8'b0, w_drop} + {8'b0, i_drop};
    drop_d   = drop_sum[8] ? 8'hff : drop_sum[7:0];
  end

  // Bus registers. Valid is high for one cycle per pop; data and tag hold between pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wval_q <= '0; row_q <= '0; vy_q <= 1'b0;
      ival_q <= '0; col_q <= '0; vx_q <= 1'b0;
    end else begin
      vy_q <= w_pop;
      vx_q <= i_pop;
      if (w_pop) {row_q, wval_q} <= w_dout;
      if (i_pop) {col_q, ival_q} <= i_dout;
    end
  end

  // Job sequencing: counts are latched at start, and beats are accepted and drained until both channels finish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0; icnt_q <= '0;
      wacc_q  <= '0; iacc_q <= '0;
      drop_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          wcnt_q  <= w_count;
          icnt_q  <= i_count;
          wacc_q  <= '0;
          iacc_q  <= '0;
          drop_q  <= '0;
          state_q <= RUN;
        end
        RUN: begin
          wacc_q <= wacc_q + {7'b0, w_fire};
          iacc_q <= iacc_q + {7'b0, i_fire};
          drop_q <= drop_d;
          if ((wacc_q == wcnt_q) && (iacc_q == icnt_q)) state_q <= FLUSH;
        end
        FLUSH: if (w_empty && i_empty && !w_pop && !i_pop) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign weight_val_in = wval_q;
  assign tag_row       = row_q;
  assign valid_y       = vy_q;
  assign image_val_in  = ival_q;
  assign tag_col       = col_q;
  assign valid_x       = vx_q;
  assign busy          = (state_q == RUN) || (state_q == FLUSH);
  assign done          = (state_q == DONE);
  assign drop_cnt      = drop_q;
endmodule

// File: doc/pe_mcast_scatter.md
PE_MCAST_SCATTER -- requirements
Module: pe_mcast_scatter

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  sole clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job start pulse
- w_count  in  8  weight beats in the job (0 = none)
- i_count  in  8  image beats in the job (0 = none)
- w_data  in  16  upstream weight value
- w_tag  in  4  destination PE row for w_data
- w_valid  in  1  upstream weight beat valid
- w_ready  out  1  block accepts weight beat
- i_data  in  16  upstream image value
- i_tag  in  4  destination PE column for i_data
- i_valid  in  1  upstream image beat valid
- i_ready  out  1  block accepts image beat
- grid_stall  in  1  grid cannot take multicast beats this cycle
- weight_val_in  out  16  Y-bus weight value to grid
- tag_row  out  4  Y-bus row tag
- valid_y  out  1  Y-bus beat valid
- image_val_in  out  16  X-bus image value to grid
- tag_col  out  4  X-bus column tag
- valid_x  out  1  X-bus beat valid
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- drop_cnt  out  8  out-of-range tags dropped in current job

Function
REQ-002 FSM states SHALL be IDLE, RUN, FLUSH, DONE.
REQ-003 IDLE->RUN on start=1; latch w_count and i_count; clear accept counters and drop_cnt.
REQ-004 start SHALL be ignored outside IDLE.
REQ-005 Handshake: beat accepted on an edge where valid and ready are both 1.
REQ-006 Each channel SHALL have a 4-entry FIFO.
REQ-007 w_ready = (state==RUN) AND FIFO not full AND accepted weight beats < latched w_count; i_ready is identical for the image channel.
REQ-008 Full FIFO deasserts ready even if a pop occurs that cycle; no bypass.
REQ-009 Accepted beat with w_tag>11 or i_tag>13: counted as accepted, not enqueued; drop_cnt increments, saturating at 255.
REQ-010 In RUN or FLUSH, when grid_stall=0 and a channel FIFO is non-empty, pop one entry into that channel's registered bus outputs with valid high for exactly one cycle.
REQ-011 Otherwise valid_x/valid_y SHALL be 0; data and tag outputs hold their last value.
REQ-012 Minimum latency: a beat accepted at edge N appears on the bus after edge N+1.
REQ-013 Channels SHALL be independent; valid_x and valid_y may both be high in one cycle.
REQ-014 Each channel SHALL preserve order.
REQ-015 RUN->FLUSH when both channels have accepted their latched counts; zero counts satisfy this immediately.
REQ-016 FLUSH->DONE when both FIFOs are empty and no bus beat is issuing that cycle.
REQ-017 DONE asserts done=1 for one cycle, then returns to IDLE.
REQ-018 busy=1 in RUN and FLUSH.
REQ-019 drop_cnt SHALL hold its value after DONE until the next start.

Reset
REQ-020 rst=0 SHALL immediately force:
- state IDLE; FIFOs empty; counters 0
- all bus data, tags and valids 0
- w_ready, i_ready, busy, done, drop_cnt 0
REQ-021 Reset asserted mid-job SHALL abandon the job; no done pulse.
REQ-022 After reset release, operation SHALL resume only on a new start.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Single beat: start, w_count=1, i_count=1; weight 3 tag 2 and image 30 tag 2 accepted same edge. Required: valid_y and valid_x high together for one cycle with those values; done follows; drop_cnt=0.
- Stall/full: w_count=6, grid_stall=1 for 10 cycles. Required: w_ready drops after 4 beats, no valid_y during stall; all 6 beats issued in order once stall clears.
- Tag range: w_count=3 with tags 5, 12, 15. Required: only tag 5 issued; drop_cnt=2; done pulses.
- Zero job: start with both counts 0. Required: RUN, FLUSH, DONE in consecutive cycles; no valids.
- Mid-job reset: rst=0 while 2 beats are queued. Required: valid_x/valid_y drop to 0 asynchronously, busy=0, no done; a restarted job completes normally.
